// File: rtl/ddr_pkg.sv
// ============================================================================
// ddr_pkg : lane codes, scheduler FSM states and difficulty-to-interval lookup
// Revision: 1.0
// ============================================================================
`default_nettype none

package ddr_pkg;

  localparam logic [1:0] LANE_LEFT  = 2'd0;
  localparam logic [1:0] LANE_DOWN  = 2'd1;
  localparam logic [1:0] LANE_UP    = 2'd2;
  localparam logic [1:0] LANE_RIGHT = 2'd3;

  // Spawn interval in beats for each difficulty switch setting
  localparam int unsigned INTERVAL_SW0 = 4;
  localparam int unsigned INTERVAL_SW1 = 2;
  localparam int unsigned INTERVAL_SW2 = 1;
  localparam int unsigned INTERVAL_SW3 = 1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_BEAT = 3'd1,
    ST_REQ       = 3'd2,
    ST_MAP       = 3'd3,
    ST_HOLD      = 3'd4
  } state_e;

  // Last beat_cnt value of an interval (interval - 1)
  function automatic logic [1:0] beat_last(input logic [1:0] sw);
    case (sw)
      2'd0:    return 2'(INTERVAL_SW0 - 1);
      2'd1:    return 2'(INTERVAL_SW1 - 1);
      2'd2:    return 2'(INTERVAL_SW2 - 1);
      default: return 2'(INTERVAL_SW3 - 1);
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/lane_mapper.sv
// ============================================================================
// lane_mapper : maps a candidate lane to the spawned lane with anti-repeat
// Revision: 1.0
// ============================================================================
`default_nettype none

module lane_mapper
  import ddr_pkg::*;
#(
  parameter int MAX_REPEAT = 2,
  parameter int REP_W      = 2
) (
  input  logic [1:0]       cand,
  input  logic [1:0]       last_lane,
  input  logic [REP_W-1:0] repeat_cnt,
  input  logic             dbl_req,
  output logic [1:0]       lane,
  output logic [REP_W-1:0] repeat_next,
  output logic             dbl
);

  always_comb begin
    lane        = cand;
    repeat_next = '0;
    dbl         = dbl_req;
    if (cand == last_lane) begin
      // Run limit reached: bump to the next lane, wrapping right back to left
      if (repeat_cnt == REP_W'(MAX_REPEAT - 1)) begin
        lane = cand + 2'd1;
      end else begin
        repeat_next = repeat_cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/note_spawn_scheduler.sv
// ============================================================================
// note_spawn_scheduler : beat-driven arrow spawn sequencer (RNG -> lane -> display)
// Optional double notes on sw=3 enabled by defining DOUBLE_NOTE_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module note_spawn_scheduler
  import ddr_pkg::*;
#(
  parameter int RND_W      = 8,
  parameter int MAX_REPEAT = 2,
  parameter int DROP_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              beat_tick,
  input  logic [1:0]        sw,
  output logic              rnd_req,
  input  logic              rnd_valid,
  input  logic [RND_W-1:0]  rnd_num,
  output logic              spawn_valid,
  input  logic              spawn_ready,
  output logic [1:0]        spawn_lane,
  output logic              spawn_double,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int REP_W = $clog2(MAX_REPEAT + 1);
`ifdef DOUBLE_NOTE_EN
  localparam int CAP_W = 3;
`else
  localparam int CAP_W = 2;
`endif

  state_e             state_q, state_d;
  logic [1:0]         beat_cnt_q, beat_cnt_d;
  logic               pending_q, pending_d;
  logic [DROP_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic [CAP_W-1:0]   cap_q, cap_d;
  logic [1:0]         last_lane_q, last_lane_d;
  logic [REP_W-1:0]   repeat_q, repeat_d;
  logic [1:0]         lane_q, lane_d;
  logic               double_q, double_d;

  logic               busy;
  logic               ticking;
  logic               due;
  logic               dbl_req;
  logic [1:0]         map_lane;
  logic [REP_W-1:0]   map_repeat;
  logic               map_dbl;

`ifdef DOUBLE_NOTE_EN
  assign dbl_req = (sw == 2'd3) && cap_q[2];
`else
  assign dbl_req = 1'b0;
`endif

  lane_mapper #(
    .MAX_REPEAT (MAX_REPEAT),
    .REP_W      (REP_W)
  ) u_lane_mapper (
    .cand        (cap_q[1:0]),
    .last_lane   (last_lane_q),
    .repeat_cnt  (repeat_q),
    .dbl_req     (dbl_req),
    .lane        (map_lane),
    .repeat_next (map_repeat),
    .dbl         (map_dbl)
  );

  assign busy    = (state_q == ST_REQ) || (state_q == ST_MAP) || (state_q == ST_HOLD);
  assign ticking = beat_tick && (state_q != ST_IDLE);
  // ">=" lets a shortened interval wrap on the next tick after an sw change
  assign due     = ticking && (beat_cnt_q >= beat_last(sw));

  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    pending_d   = pending_q;
    drop_cnt_d  = drop_cnt_q;
    cap_d       = cap_q;
    last_lane_d = last_lane_q;
    repeat_d    = repeat_q;
    lane_d      = lane_q;
    double_d    = double_q;

    if (ticking) begin
      beat_cnt_d = due ? 2'd0 : beat_cnt_q + 2'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_WAIT_BEAT;
      end
      ST_WAIT_BEAT: begin
        if (due || pending_q) state_d = ST_REQ;
        // A pending spawn is consumed first; a simultaneous due one takes its place
        if (pending_q && !due) pending_d = 1'b0;
      end
      ST_REQ: begin
        if (rnd_valid) begin
          cap_d   = rnd_num[CAP_W-1:0];
          state_d = ST_MAP;
        end
      end
      ST_MAP: begin
        lane_d      = map_lane;
        last_lane_d = map_lane;
        repeat_d    = map_repeat;
        double_d    = map_dbl;
        state_d     = ST_HOLD;
      end
      ST_HOLD: begin
        if (spawn_ready) state_d = ST_WAIT_BEAT;
      end
      default: state_d = ST_IDLE;
    endcase

    if (busy && due) begin
      if (!pending_q) begin
        pending_d = 1'b1;
      end else if (drop_cnt_q != {DROP_W{1'b1}}) begin
        drop_cnt_d = drop_cnt_q + 1'b1;
      end
    end

    // Disabling abandons any spawn in flight; drop history and last lane survive
    if (!enable) begin
      state_d    = ST_IDLE;
      beat_cnt_d = 2'd0;
      pending_d  = 1'b0;
      repeat_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      beat_cnt_q  <= 2'd0;
      pending_q   <= 1'b0;
      drop_cnt_q  <= '0;
      cap_q       <= '0;
      last_lane_q <= LANE_LEFT;
      repeat_q    <= '0;
      lane_q      <= LANE_LEFT;
      double_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      pending_q   <= pending_d;
      drop_cnt_q  <= drop_cnt_d;
      cap_q       <= cap_d;
      last_lane_q <= last_lane_d;
      repeat_q    <= repeat_d;
      lane_q      <= lane_d;
      double_q    <= double_d;
    end
  end

  assign rnd_req     = (state_q == ST_REQ);
  assign spawn_valid = (state_q == ST_HOLD);
  assign spawn_lane  = spawn_valid ? lane_q : LANE_LEFT;
  assign drop_cnt    = drop_cnt_q;

`ifdef DOUBLE_NOTE_EN
  assign spawn_double = spawn_valid && double_q;
  logic unused_bits;
  assign unused_bits = ^rnd_num;
`else
  assign spawn_double = 1'b0;
  logic unused_bits;
  assign unused_bits = ^{rnd_num, double_q};
`endif

endmodule

`default_nettype wire

// File: tb/tb_note_spawn_scheduler.sv
// ============================================================================
// tb_note_spawn_scheduler : directed, table-driven bench for note_spawn_scheduler
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_note_spawn_scheduler;

`ifdef DOUBLE_NOTE_EN
  localparam logic DBL_EXP = 1'b1;
`else
  localparam logic DBL_EXP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       beat_tick;
  logic [1:0] sw;
  logic       rnd_req;
  logic       rnd_valid;
  logic [7:0] rnd_num;
  logic       spawn_valid;
  logic       spawn_ready;
  logic [1:0] spawn_lane;
  logic       spawn_double;
  logic [7:0] drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int n_xfer   = 0;
  logic [1:0] xfer_lane [$];

  typedef struct {
    logic [1:0] sw;
    logic [7:0] rnd;
    logic [1:0] lane;
    logic       dbl;
  } vec_t;

  vec_t tbl [12];

  note_spawn_scheduler #(
    .RND_W      (8),
    .MAX_REPEAT (2),
    .DROP_W     (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .beat_tick    (beat_tick),
    .sw           (sw),
    .rnd_req      (rnd_req),
    .rnd_valid    (rnd_valid),
    .rnd_num      (rnd_num),
    .spawn_valid  (spawn_valid),
    .spawn_ready  (spawn_ready),
    .spawn_lane   (spawn_lane),
    .spawn_double (spawn_double),
    .drop_cnt     (drop_cnt)
  );

  always #5 clk = ~clk;

  // Record every accepted spawn (transfer happens on the following rising edge)
  always @(negedge clk) begin
    if (rst_n && spawn_valid && spawn_ready) begin
      n_xfer++;
      xfer_lane.push_back(spawn_lane);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_ticks(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      beat_tick = 1'b1;
      step();
      beat_tick = 1'b0;
      repeat (gap) step();
    end
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    enable      = 1'b0;
    beat_tick   = 1'b0;
    sw          = 2'd0;
    rnd_valid   = 1'b0;
    rnd_num     = 8'h00;
    spawn_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  // One spawn at interval 1: checks latency, lane, double and the handshake drop
  task automatic spawn_one(input int idx, input vec_t v);
    int lat;
    sw          = v.sw;
    rnd_num     = v.rnd;
    rnd_valid   = 1'b1;
    spawn_ready = 1'b1;
    beat_tick   = 1'b1;
    step();
    beat_tick = 1'b0;
    lat = 1;
    while (!spawn_valid && lat < 10) begin
      step();
      lat++;
    end
    check($sformatf("vec%0d latency", idx), lat, 3);
    check($sformatf("vec%0d lane", idx), int'(spawn_lane), int'(v.lane));
    check($sformatf("vec%0d double", idx), int'(spawn_double), int'(v.dbl));
    step();
    check($sformatf("vec%0d valid_drop", idx), int'(spawn_valid), 0);
  endtask

  initial begin
    int n0;
    int seen;

    tbl[0]  = '{2'd2, 8'h01, 2'd1, 1'b0};
    tbl[1]  = '{2'd2, 8'h01, 2'd1, 1'b0};
    tbl[2]  = '{2'd2, 8'h01, 2'd2, 1'b0};
    tbl[3]  = '{2'd2, 8'h03, 2'd3, 1'b0};
    tbl[4]  = '{2'd2, 8'h03, 2'd3, 1'b0};
    tbl[5]  = '{2'd2, 8'h03, 2'd0, 1'b0};
    tbl[6]  = '{2'd2, 8'h00, 2'd0, 1'b0};
    tbl[7]  = '{2'd2, 8'h04, 2'd1, 1'b0};
    tbl[8]  = '{2'd3, 8'h06, 2'd2, DBL_EXP};
    tbl[9]  = '{2'd3, 8'h02, 2'd2, 1'b0};
    tbl[10] = '{2'd3, 8'h06, 2'd3, DBL_EXP};
    tbl[11] = '{2'd2, 8'hFF, 2'd3, 1'b0};

    // Reset state
    do_reset();
    check("rst spawn_valid", int'(spawn_valid), 0);
    check("rst rnd_req", int'(rnd_req), 0);
    check("rst spawn_lane", int'(spawn_lane), 0);
    check("rst spawn_double", int'(spawn_double), 0);
    check("rst drop_cnt", int'(drop_cnt), 0);

    // sw=0: 8 beats give 2 spawns (lanes 1,1); 4 more beats give lane 2
    enable      = 1'b1;
    sw          = 2'd0;
    rnd_valid   = 1'b1;
    rnd_num     = 8'h01;
    spawn_ready = 1'b1;
    step();
    step();
    n0 = n_xfer;
    run_ticks(8, 6);
    check("sw0 spawn count", n_xfer - n0, 2);
    if (n_xfer - n0 >= 2) begin
      check("sw0 lane a", int'(xfer_lane[n0]), 1);
      check("sw0 lane b", int'(xfer_lane[n0 + 1]), 1);
    end
    run_ticks(4, 6);
    check("sw0 spawn count 3", n_xfer - n0, 3);
    if (n_xfer - n0 >= 3) check("sw0 lane c", int'(xfer_lane[n0 + 2]), 2);

    // Table of single spawns from a fresh lane history
    do_reset();
    enable = 1'b1;
    step();
    step();
    for (int i = 0; i < 12; i++) spawn_one(i, tbl[i]);

    // Overrun while the display stalls
    do_reset();
    enable    = 1'b1;
    sw        = 2'd2;
    rnd_valid = 1'b1;
    rnd_num   = 8'h01;
    step();
    step();
    run_ticks(1, 4);
    check("ovr valid", int'(spawn_valid), 1);
    check("ovr lane", int'(spawn_lane), 1);
    run_ticks(1, 3);
    check("ovr drop after pending", int'(drop_cnt), 0);
    run_ticks(1, 3);
    check("ovr drop after drop", int'(drop_cnt), 1);
    check("ovr lane stable", int'(spawn_lane), 1);
    check("ovr valid stable", int'(spawn_valid), 1);

    // Asynchronous reset in the middle of HOLD
    #2;
    rst_n = 1'b0;
    #1;
    check("arst spawn_valid", int'(spawn_valid), 0);
    check("arst spawn_lane", int'(spawn_lane), 0);
    check("arst rnd_req", int'(rnd_req), 0);
    check("arst drop_cnt", int'(drop_cnt), 0);
    step();
    rst_n = 1'b1;
    step();
    step();
    check("arst release drop_cnt", int'(drop_cnt), 0);
    beat_tick = 1'b1;
    step();
    beat_tick = 1'b0;
    check("arst release wait_beat", int'(rnd_req), 1);
    repeat (4) step();

    // Beat tick on the same edge as the HOLD handshake becomes a pending spawn
    do_reset();
    enable    = 1'b1;
    sw        = 2'd2;
    rnd_valid = 1'b1;
    rnd_num   = 8'h02;
    step();
    step();
    run_ticks(1, 4);
    check("hs valid", int'(spawn_valid), 1);
    n0          = n_xfer;
    spawn_ready = 1'b1;
    beat_tick   = 1'b1;
    step();
    beat_tick = 1'b0;
    check("hs valid drop", int'(spawn_valid), 0);
    seen = 0;
    for (int k = 0; k < 8 && seen == 0; k++) begin
      step();
      if (spawn_valid) seen = 1;
    end
    check("hs pending spawn", seen, 1);
    check("hs pending lane", int'(spawn_lane), 2);
    step();
    check("hs xfer count", n_xfer - n0, 2);

    // enable dropped while in REQ clears beat count and pending
    do_reset();
    enable    = 1'b1;
    sw        = 2'd0;
    rnd_valid = 1'b0;
    rnd_num   = 8'h01;
    spawn_ready = 1'b1;
    step();
    step();
    run_ticks(4, 2);
    check("en req", int'(rnd_req), 1);
    run_ticks(2, 2);
    check("en req held", int'(rnd_req), 1);
    enable = 1'b0;
    step();
    check("en off rnd_req", int'(rnd_req), 0);
    check("en off spawn_valid", int'(spawn_valid), 0);
    step();
    rnd_valid = 1'b1;
    enable    = 1'b1;
    step();
    step();
    n0 = n_xfer;
    run_ticks(3, 6);
    check("en early spawn", n_xfer - n0, 0);
    run_ticks(1, 6);
    check("en full interval spawn", n_xfer - n0, 1);
    if (n_xfer - n0 >= 1) check("en lane", int'(xfer_lane[n0]), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
